// File: rtl/timer_pkg.sv
// Shared types and constants for the timer / PWM capture blocks.
// State encoding, counter width and saturating increment.
package timer_pkg;

  localparam int COUNT_W = 32;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } cap_state_e;

  function automatic logic [COUNT_W-1:0] sat_inc(
    input logic [COUNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/pwm_capture_sync_edge_det.sv
// Multi-flop synchronizer with rise/fall detection.
// Edges are flagged the cycle the synchronized level changes.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // shift the async input through the sync chain, keep last level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with stuck-level timeout.
// Results land one cycle after the completing rising edge.
module pwm_capture
  import timer_pkg::*;
#(
  parameter int                 SYNC_STAGES = 2,
  parameter logic [COUNT_W-1:0] TIMEOUT     = 32'hFFFF_FFFF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               GO_EN,
  input  logic               MODE,
  input  logic               PWM_IN,
  output logic [COUNT_W-1:0] PERIOD_CNT,
  output logic [COUNT_W-1:0] HIGH_CNT,
  output logic               VALID,
  output logic               IRQ_TRG,
  output logic               STUCK,
  output logic               STUCK_LVL
);

  cap_state_e state_q, state_d;

  logic level, rise, fall;
  logic timeout_hit;

  logic [COUNT_W-1:0] period_q, high_q, idle_q;
  logic [COUNT_W-1:0] per_out_q, high_out_q;
  logic               valid_q, stuck_q, lvl_q;

  logic track, cnt_start, inc_period, inc_high;
  logic do_load, do_stuck;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (PWM_IN),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  // an edge in the same cycle always beats the timeout
  assign timeout_hit = (idle_q == TIMEOUT - CNT_ONE) && !(rise || fall);

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic; dropping GO_EN wins over everything
  always_comb begin
    state_d = state_q;
    if (!GO_EN) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM:  if (rise) state_d = ST_HIGH;
        ST_HIGH: begin
          if (fall)             state_d = ST_LOW;
          else if (timeout_hit) state_d = ST_ARM;
        end
        ST_LOW: begin
          if (rise)             state_d = MODE ? ST_DONE : ST_HIGH;
          else if (timeout_hit) state_d = ST_ARM;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // per-state datapath controls
  always_comb begin
    track      = 1'b0;
    cnt_start  = 1'b0;
    inc_period = 1'b0;
    inc_high   = 1'b0;
    do_load    = 1'b0;
    do_stuck   = 1'b0;
    if (GO_EN) begin
      unique case (state_q)
        ST_ARM: begin
          track     = 1'b1;
          cnt_start = rise;
          do_stuck  = timeout_hit;
        end
        ST_HIGH: begin
          track      = 1'b1;
          inc_period = 1'b1;
          inc_high   = !fall;
          do_stuck   = timeout_hit;
        end
        ST_LOW: begin
          track      = 1'b1;
          do_load    = rise;
          cnt_start  = rise;
          inc_period = !rise;
          do_stuck   = timeout_hit;
        end
        default: ;
      endcase
    end
  end

  // counters, idle timer and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      period_q   <= '0;
      high_q     <= '0;
      idle_q     <= '0;
      per_out_q  <= '0;
      high_out_q <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
      lvl_q      <= 1'b0;
    end else begin
      valid_q <= do_load;
      stuck_q <= do_stuck;
      if (do_load) begin
        per_out_q  <= period_q;
        high_out_q <= high_q;
      end
      if (do_stuck) lvl_q <= level;
      if (cnt_start) begin
        period_q <= CNT_ONE;
        high_q   <= CNT_ONE;
      end else if (!track) begin
        period_q <= '0;
        high_q   <= '0;
      end else begin
        if (inc_period) period_q <= sat_inc(period_q);
        if (inc_high)   high_q   <= sat_inc(high_q);
      end
      if (!track)                    idle_q <= '0;
      else if (rise || fall || do_stuck) idle_q <= CNT_ONE;
      else                           idle_q <= sat_inc(idle_q);
    end
  end

  assign PERIOD_CNT = per_out_q;
  assign HIGH_CNT   = high_out_q;
  assign VALID      = valid_q;
  assign STUCK      = stuck_q;
  assign STUCK_LVL  = lvl_q;
  assign IRQ_TRG    = valid_q | stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed + randomized bench for pwm_capture.
// Expected results come from the high/low durations driven.
module tb_pwm_capture;

  localparam int SYNC = 2;
  localparam int TMO  = 20;
  localparam int LAT  = SYNC + 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        go, mode, pwm;
  logic [31:0] per, hi;
  logic        valid, irq, stuck, lvl;
  logic        go_lb, pwm_lb;
  logic [31:0] lb_per, lb_hi;
  logic        lb_valid, lb_irq, lb_stuck, lb_lvl;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          c;
    logic [31:0] p;
    logic [31:0] h;
  } ev_t;

  ev_t  vq[$];
  int   sq_c[$];
  logic sq_l[$];
  int   irq_bad = 0;
  int   lb_vn   = 0;
  int   lb_sn   = 0;
  int   hs[$];
  int   ls[$];
  int   t_mark;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  pwm_capture #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (32'd20)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .GO_EN     (go),
    .MODE      (mode),
    .PWM_IN    (pwm),
    .PERIOD_CNT(per),
    .HIGH_CNT  (hi),
    .VALID     (valid),
    .IRQ_TRG   (irq),
    .STUCK     (stuck),
    .STUCK_LVL (lvl)
  );

  pwm_capture #(
    .SYNC_STAGES(SYNC)
  ) dut_lb (
    .CLK       (CLK),
    .RST       (RST),
    .GO_EN     (go_lb),
    .MODE      (1'b0),
    .PWM_IN    (pwm_lb),
    .PERIOD_CNT(lb_per),
    .HIGH_CNT  (lb_hi),
    .VALID     (lb_valid),
    .IRQ_TRG   (lb_irq),
    .STUCK     (lb_stuck),
    .STUCK_LVL (lb_lvl)
  );

  always @(negedge CLK) begin
    if (valid === 1'b1) vq.push_back('{cyc, per, hi});
    if (stuck === 1'b1) begin
      sq_c.push_back(cyc);
      sq_l.push_back(lvl);
    end
    if (!RST && irq !== (valid | stuck)) irq_bad++;
    if (lb_valid === 1'b1) lb_vn++;
    if (lb_stuck === 1'b1) lb_sn++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pwm_per(input int h, input int l);
    pwm = 1'b1;
    tick(h);
    pwm = 1'b0;
    tick(l);
  endtask

  task automatic clr_ev();
    vq.delete();
    sq_c.delete();
    sq_l.delete();
  endtask

  // continuous capture of hs/ls plus a closing rise
  task automatic run_seq(input string tag);
    clr_ev();
    mode = 1'b0;
    go   = 1'b1;
    tick(2);
    foreach (hs[i]) pwm_per(hs[i], ls[i]);
    pwm = 1'b1;
    tick(2);
    pwm = 1'b0;
    tick(2);
    go = 1'b0;
    tick(3);
    chk({tag, "_n"}, vq.size(), hs.size());
    for (int i = 0; i < hs.size() && i < vq.size(); i++) begin
      chk({tag, "_per"}, vq[i].p, hs[i] + ls[i]);
      chk({tag, "_hi"}, vq[i].h, hs[i]);
    end
    chk({tag, "_stuck"}, sq_c.size(), 0);
  endtask

  initial begin
    RST = 1'b1; go = 1'b0; mode = 1'b0; pwm = 1'b0;
    go_lb = 1'b0; pwm_lb = 1'b0;

    // reset with toggling input
    for (int i = 0; i < 3; i++) begin
      pwm = ~pwm;
      tick();
    end
    chk("rst_per", per, 0);
    chk("rst_hi", hi, 0);
    chk("rst_flags", {28'd0, valid, irq, stuck, lvl}, 0);
    RST = 1'b0;
    pwm = 1'b0;
    clr_ev();
    repeat (3) pwm_per(2, 3);
    chk("off_per", per, 0);
    chk("off_valid", vq.size(), 0);
    chk("off_stuck", sq_c.size(), 0);

    // 3 high / 7 low, four periods
    clr_ev();
    go = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) t_mark = cyc;
      pwm_per(3, 7);
    end
    go = 1'b0;
    tick(3);
    chk("c37_n", vq.size(), 3);
    if (vq.size() >= 2) begin
      chk("c37_lat", vq[0].c, t_mark + LAT);
      chk("c37_gap", vq[1].c - vq[0].c, 10);
    end
    foreach (vq[i]) begin
      chk("c37_per", vq[i].p, 10);
      chk("c37_hi", vq[i].h, 3);
    end
    chk("c37_stuck", sq_c.size(), 0);

    // random periods, edges always closer than the timeout
    hs.delete();
    ls.delete();
    for (int i = 0; i < 6; i++) begin
      hs.push_back($urandom_range(9, 1));
      ls.push_back($urandom_range(9, 1));
    end
    run_seq("rnd");

    // edge landing on the timeout cycle wins
    hs.delete();
    ls.delete();
    repeat (2) begin
      hs.push_back(TMO - 1);
      ls.push_back(TMO - 1);
    end
    run_seq("edge_tmo");

    // one-shot
    clr_ev();
    mode = 1'b1;
    go   = 1'b1;
    tick(2);
    repeat (3) pwm_per(5, 5);
    pwm = 1'b1;
    tick(2);
    pwm = 1'b0;
    tick(5);
    chk("os_n", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("os_per", vq[0].p, 10);
      chk("os_hi", vq[0].h, 5);
    end
    go = 1'b0;
    tick(2);
    go = 1'b1;
    tick(2);
    repeat (2) pwm_per(5, 5);
    pwm = 1'b1;
    tick(2);
    pwm = 1'b0;
    tick(4);
    chk("os_rearm_n", vq.size(), 2);
    chk("os_stuck", sq_c.size(), 0);
    go   = 1'b0;
    mode = 1'b0;
    tick(2);

    // constant low while armed
    clr_ev();
    go = 1'b1;
    tick(TMO + 5);
    chk("arm_stuck_n", sq_c.size(), 1);
    if (sq_c.size() > 0) chk("arm_stuck_lvl", sq_l[0], 0);
    go = 1'b0;
    tick(2);

    // stuck high after one rise
    go = 1'b1;
    tick(2);
    clr_ev();
    pwm    = 1'b1;
    t_mark = cyc;
    tick(TMO + 5);
    chk("hi_stuck_n", sq_c.size(), 1);
    if (sq_c.size() > 0) begin
      chk("hi_stuck_t", sq_c[0], t_mark + SYNC + TMO);
      chk("hi_stuck_lvl", sq_l[0], 1);
    end
    chk("hi_stuck_per", per, 10);
    chk("hi_stuck_hi", hi, 5);
    chk("hi_stuck_valid", vq.size(), 0);
    go  = 1'b0;
    pwm = 1'b0;
    tick(3);

    // GO_EN dropped d cycles before the completing sync rise
    for (int d = 0; d <= 2; d += 2) begin
      clr_ev();
      go = 1'b1;
      tick(2);
      pwm_per(4, 4);
      pwm = 1'b1;
      tick(SYNC - d);
      go = 1'b0;
      tick(2);
      pwm = 1'b0;
      tick(4);
      chk("drop_valid", vq.size(), 0);
      chk("drop_stuck", sq_c.size(), 0);
    end
    hs.delete();
    ls.delete();
    repeat (2) begin
      hs.push_back(4);
      ls.push_back(4);
    end
    run_seq("c44");

    // loopback from a timer with TOT_CNT=100, DUTY_CNT=25
    go_lb = 1'b1;
    for (int i = 0; i < 500; i++) begin
      pwm_lb = ((i % 100) < 25);
      tick();
    end
    tick(4);
    chk("lb_n", lb_vn, 4);
    chk("lb_per", lb_per, 100);
    chk("lb_hi", lb_hi, 25);
    chk("lb_stuck", lb_sn, 0);
    go_lb = 1'b0;

    chk("irq_coincide", irq_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
